cube: RTL

CUBE -- requirements
Module: cube

---
 rtl/cube.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cube.sv
// -----------------------------------------------------------------------------
// cube -- sequential unsigned cube, y = a * a * a
//
// The block uses two shift-add multiplication passes, one multiplier bit per
// clock, so every operation has the same latency.
//   MUL1 : p   = a * a  (16-bit partial product, 8 cycles)
//   MUL2 : acc = p * a  (24-bit accumulator,     8 cycles)
// The result is loaded into y_bo on the last MUL2 edge, and done_o pulses then.
//
// Ports
//   clk_i    in   1   system clock, rising edge
//   rst_ni   in   1   asynchronous active-low reset
//   start_i  in   1   request strobe, only looked at while idle
//   a_bi     in   8   unsigned operand, captured on the accepting edge
//   busy_o   out  1   high for exactly 16 cycles per operation
//   done_o   out  1   one-cycle pulse when y_bo is updated
//   y_bo     out 24   last result, held between updates
// -----------------------------------------------------------------------------
module cube (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [7:0]  a_bi,
    output logic        busy_o,
    output logic        done_o,
    output logic [23:0] y_bo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  a_r,     a_s;
    logic [2:0]  cnt_r,   cnt_s;
    logic [15:0] p_r,     p_s;
    logic [23:0] acc_r,   acc_s;
    logic [23:0] y_r,     y_s;
    logic        busy_r,  busy_s;
    logic        done_r,  done_s;

    // Shifted addends for the current multiplier bit.
    logic [15:0] p_add_s;
    logic [23:0] acc_add_s;
    logic [23:0] acc_sum_s;

    // Addend generation and the MUL2 running sum. The sum includes the bit
    // being processed, so the final edge can load y directly from it.
    always_comb begin
        p_add_s   = {8'd0, a_r} << cnt_r;
        acc_add_s = {8'd0, p_r} << cnt_r;
        if (a_r[cnt_r]) begin
            acc_sum_s = acc_r + acc_add_s;
        end else begin
            acc_sum_s = acc_r;
        end
    end

    // Next-state and datapath update for the IDLE / MUL1 / MUL2 sequence.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        cnt_s   = cnt_r;
        p_s     = p_r;
        acc_s   = acc_r;
        y_s     = y_r;
        busy_s  = busy_r;
        done_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_s = MUL1;
                    a_s     = a_bi;
                    cnt_s   = 3'd0;
                    p_s     = 16'd0;
                    busy_s  = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            MUL1: begin
                if (a_r[cnt_r]) begin
                    p_s = p_r + p_add_s;
                end else begin
                    p_s = p_r;
                end
                cnt_s = cnt_r + 3'd1;
                // Counter wrapping 7 -> 0 ends the first pass.
                if (cnt_r == 3'd7) begin
                    state_s = MUL2;
                    acc_s   = 24'd0;
                end else begin
                    state_s = MUL1;
                end
            end
            MUL2: begin
                acc_s = acc_sum_s;
                cnt_s = cnt_r + 3'd1;
                if (cnt_r == 3'd7) begin
                    state_s = IDLE;
                    y_s     = acc_sum_s;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    state_s = MUL2;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything asynchronously,
    // which also aborts an operation in flight without a done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            a_r     <= 8'd0;
            cnt_r   <= 3'd0;
            p_r     <= 16'd0;
            acc_r   <= 24'd0;
            y_r     <= 24'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            cnt_r   <= cnt_s;
            p_r     <= p_s;
            acc_r   <= acc_s;
            y_r     <= y_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign busy_o = busy_r;
    assign done_o = done_r;
    assign y_bo   = y_r;

endmodule
